// File: rtl/sdq_pkg.sv
// Shared types and helpers for the store data queue drain controller.
// Queue depth is not a power of two, so pointer arithmetic goes through sdq_ptr_inc.
package sdq_pkg;

  localparam int SDQ_ENTRIES = 17;
  localparam int SDQ_DATA_W  = 64;
  localparam int SDQ_IDX_W   = 5;
  localparam int SDQ_CNT_W   = 5;

  typedef logic [SDQ_IDX_W-1:0]  sdq_idx_t;
  typedef logic [SDQ_CNT_W-1:0]  sdq_cnt_t;
  typedef logic [SDQ_DATA_W-1:0] sdq_data_t;

  localparam sdq_idx_t SDQ_LAST = sdq_idx_t'(SDQ_ENTRIES - 1);
  localparam sdq_cnt_t SDQ_FULL = sdq_cnt_t'(SDQ_ENTRIES);

  // Wraps from the last entry back to 0 rather than at the index width.
  function automatic sdq_idx_t sdq_ptr_inc(input sdq_idx_t p);
    return (p == SDQ_LAST) ? '0 : p + sdq_idx_t'(1);
  endfunction

endpackage

// File: rtl/sdq_drain_ctrl_if.sv
// D-cache store request channel plus its ack/nack completion signals.
interface sdq_drain_ctrl_if;
  import sdq_pkg::*;

  logic      dc_req_valid;
  logic      dc_req_ready;
  sdq_idx_t  dc_req_idx;
  sdq_data_t dc_req_data;
  logic      dc_ack;
  logic      dc_nack;

  modport master (
    output dc_req_valid, dc_req_idx, dc_req_data,
    input  dc_req_ready, dc_ack, dc_nack
  );

  modport slave (
    input  dc_req_valid, dc_req_idx, dc_req_data,
    output dc_req_ready, dc_ack, dc_nack
  );

endinterface

// File: rtl/sdq_out_reg.sv
// Single-entry valid/ready output register; load wins over clear, otherwise it holds.
module sdq_out_reg
  import sdq_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      load,
  input  logic      clear,
  input  sdq_idx_t  load_idx,
  input  sdq_data_t load_data,
  output logic      valid,
  output sdq_idx_t  idx,
  output sdq_data_t data
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      idx   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      idx   <= load_idx;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sdq_drain_ctrl.sv
// Drains committed SDQ entries to the D-cache in program order, frees them on ack
// and replays everything unacked from head on nack.
module sdq_drain_ctrl
  import sdq_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  output logic             mem_r_en,
  output sdq_idx_t         mem_r_addr,
  input  sdq_data_t        mem_r_data,
  sdq_drain_ctrl_if.master dc,
  output logic             deq_free,
  output sdq_idx_t         deq_idx,
  output sdq_idx_t         head_idx,
  output logic             err
);

  sdq_idx_t head;
  sdq_idx_t rptr;
  sdq_cnt_t n_commit;
  sdq_cnt_t n_issued;

  logic full;
  logic rd;
  logic ack_ok;
  logic commit_ok;
  logic out_clear;

  // n_issued includes the buffered entry, so an ack is only legal when something beyond it is in flight.
  always_comb begin
    full      = (n_commit == SDQ_FULL);
    rd        = !reset && (n_issued < n_commit)
                && (!dc.dc_req_valid || dc.dc_req_ready) && !dc.dc_nack;
    ack_ok    = dc.dc_ack && !dc.dc_nack && (n_issued > sdq_cnt_t'(dc.dc_req_valid));
    commit_ok = commit_valid && !full;
    out_clear = dc.dc_nack || (dc.dc_req_valid && dc.dc_req_ready && !rd);
  end

  assign mem_r_en   = rd;
  assign mem_r_addr = rptr;
  assign head_idx   = head;

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      rptr     <= '0;
      n_commit <= '0;
      n_issued <= '0;
      deq_free <= 1'b0;
      deq_idx  <= '0;
      err      <= 1'b0;
    end else begin
      if (ack_ok) begin
        head <= sdq_ptr_inc(head);
      end
      if (dc.dc_nack) begin
        rptr     <= head;
        n_issued <= '0;
      end else begin
        if (rd) begin
          rptr <= sdq_ptr_inc(rptr);
        end
        n_issued <= n_issued + sdq_cnt_t'(rd) - sdq_cnt_t'(ack_ok);
      end
      n_commit <= n_commit + sdq_cnt_t'(commit_ok) - sdq_cnt_t'(ack_ok);
      deq_free <= ack_ok;
      deq_idx  <= head;
      if ((commit_valid && full) || (dc.dc_ack && !ack_ok)) begin
        err <= 1'b1;
      end
    end
  end

  sdq_out_reg u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (rd),
    .clear     (out_clear),
    .load_idx  (rptr),
    .load_data (mem_r_data),
    .valid     (dc.dc_req_valid),
    .idx       (dc.dc_req_idx),
    .data      (dc.dc_req_data)
  );

endmodule

// File: tb/tb_sdq_drain_ctrl.sv
// Directed bench for sdq_drain_ctrl: a queue-based model of unacked stores is checked
// against the DUT every cycle, plus literal expectations for the key scenarios.
module tb_sdq_drain_ctrl;
  import sdq_pkg::*;

  logic      clock;
  logic      reset;
  logic      commit_valid;
  logic      mem_r_en;
  sdq_idx_t  mem_r_addr;
  sdq_data_t mem_r_data;
  logic      deq_free;
  sdq_idx_t  deq_idx;
  sdq_idx_t  head_idx;
  logic      err;

  sdq_drain_ctrl_if dcif ();

  sdq_drain_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .commit_valid (commit_valid),
    .mem_r_en     (mem_r_en),
    .mem_r_addr   (mem_r_addr),
    .mem_r_data   (mem_r_data),
    .dc           (dcif.master),
    .deq_free     (deq_free),
    .deq_idx      (deq_idx),
    .head_idx     (head_idx),
    .err          (err)
  );

  logic [63:0] mem [SDQ_ENTRIES];
  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 0;
  int acc_log [$];

  // Model: q holds unacked committed indices oldest first; f of them are buffered or in flight.
  int q [$];
  int f   = 0;
  bit mv  = 0;
  int mi  = 0;
  int mh  = 0;
  bit mdf = 0;
  int mdi = 0;
  bit merr = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    mem_r_data = '0;
    if (int'(mem_r_addr) < SDQ_ENTRIES) mem_r_data = mem[int'(mem_r_addr)];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  function bit modelRd();
    return !reset && (f < q.size()) && (!mv || dcif.dc_req_ready) && !dcif.dc_nack;
  endfunction

  task automatic modelStep();
    bit rd;
    bit ack_ok;
    bit full;
    int rd_idx;
    int tail;
    if (reset) begin
      q.delete();
      f = 0; mv = 0; mi = 0; mh = 0; mdf = 0; mdi = 0; merr = 0;
    end else begin
      rd     = modelRd();
      rd_idx = rd ? q[f] : 0;
      tail   = (mh + q.size()) % SDQ_ENTRIES;
      full   = (q.size() == SDQ_ENTRIES);
      ack_ok = dcif.dc_ack && !dcif.dc_nack && ((f - int'(mv)) > 0);
      if ((commit_valid && full) || (dcif.dc_ack && !ack_ok)) merr = 1;
      mdf = ack_ok;
      mdi = mh;
      if (dcif.dc_nack) begin
        f  = 0;
        mv = 0;
      end else begin
        if (rd) begin
          mv = 1;
          mi = rd_idx;
        end else if (mv && dcif.dc_req_ready) begin
          mv = 0;
        end
        f = f + int'(rd) - int'(ack_ok);
      end
      if (ack_ok) begin
        void'(q.pop_front());
        mh = (mh + 1) % SDQ_ENTRIES;
      end
      if (commit_valid && !full) q.push_back(tail);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return just after it.
  task automatic applyStimulus(input bit c, input bit r, input bit a, input bit n);
    commit_valid      = c;
    dcif.dc_req_ready = r;
    dcif.dc_ack       = a;
    dcif.dc_nack      = n;
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic checkLog(input string name, input int first, input int count);
    checkOutput({name, "_count"}, 64'(acc_log.size()), 64'(count));
    for (int i = 0; i < count && i < acc_log.size(); i++)
      checkOutput($sformatf("%s_%0d", name, i), 64'(acc_log[i]), 64'((first + i) % SDQ_ENTRIES));
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      if (!reset && dcif.dc_req_valid && dcif.dc_req_ready && !dcif.dc_nack)
        acc_log.push_back(int'(dcif.dc_req_idx));
      checkOutput("valid", 64'(dcif.dc_req_valid), 64'(mv));
      if (mv) begin
        checkOutput("idx", 64'(dcif.dc_req_idx), 64'(mi));
        checkOutput("data", dcif.dc_req_data, mem[mi]);
      end
      checkOutput("head", 64'(head_idx), 64'(mh));
      checkOutput("deq_free", 64'(deq_free), 64'(mdf));
      if (mdf) checkOutput("deq_idx", 64'(deq_idx), 64'(mdi));
      checkOutput("err", 64'(err), 64'(merr));
      checkOutput("mem_r_en", 64'(mem_r_en), 64'(modelRd()));
      if (modelRd()) checkOutput("mem_r_addr", 64'(mem_r_addr), 64'(q[f]));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < SDQ_ENTRIES; i++) mem[i] = {32'hDEAD_BEEF, 16'(i), 16'(i + 1)};
    reset = 1'b1;
    commit_valid = 0; dcif.dc_req_ready = 0; dcif.dc_ack = 0; dcif.dc_nack = 0;
    applyStimulus(0, 0, 0, 0);
    chk_en = 1;
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_valid", 64'(dcif.dc_req_valid), 64'd0);
    checkOutput("rst_idx", 64'(dcif.dc_req_idx), 64'd0);
    checkOutput("rst_data", dcif.dc_req_data, 64'd0);
    checkOutput("rst_head", 64'(head_idx), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    $display("[TB] single store");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("single_valid", 64'(dcif.dc_req_valid), 64'd1);
    checkOutput("single_idx", 64'(dcif.dc_req_idx), 64'd0);
    checkOutput("single_data", dcif.dc_req_data, 64'hDEAD_BEEF_0000_0001);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("single_deq_free", 64'(deq_free), 64'd1);
    checkOutput("single_deq_idx", 64'(deq_idx), 64'd0);
    checkOutput("single_head", 64'(head_idx), 64'd1);

    $display("[TB] wrap-around and full");
    resetDut();
    acc_log.delete();
    for (int i = 0; i < 23; i++) applyStimulus(i < 20, 1, i >= 3, 0);
    checkLog("wrap", 0, 20);
    checkOutput("wrap_head", 64'(head_idx), 64'd3);
    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("full_no_err", 64'(err), 64'd0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("full_err", 64'(err), 64'd1);

    $display("[TB] backpressure");
    resetDut();
    acc_log.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("bp_valid", 64'(dcif.dc_req_valid), 64'd1);
    checkOutput("bp_idx", 64'(dcif.dc_req_idx), 64'd0);
    checkOutput("bp_data", dcif.dc_req_data, 64'hDEAD_BEEF_0000_0001);
    checkOutput("bp_mem_r_en", 64'(mem_r_en), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);
    checkLog("bp", 0, 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);

    $display("[TB] nack replay");
    resetDut();
    acc_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("nack_deq_free", 64'(deq_free), 64'd1);
    checkOutput("nack_deq_idx", 64'(deq_idx), 64'd0);
    checkLog("nack_first", 0, 4);
    acc_log.delete();
    applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0);
    checkLog("nack_replay", 1, 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0);
    checkOutput("nack_head", 64'(head_idx), 64'd4);

    $display("[TB] simultaneous events");
    resetDut();
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    acc_log.delete();
    applyStimulus(0, 1, 1, 1);
    checkOutput("acknack_err", 64'(err), 64'd1);
    checkOutput("acknack_head", 64'(head_idx), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
    checkLog("acknack_replay", 1, 2);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);

    $display("[TB] reset mid-stream");
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0);
    reset = 1'b1;
    applyStimulus(0, 1, 0, 0);
    reset = 1'b0;
    checkOutput("midrst_valid", 64'(dcif.dc_req_valid), 64'd0);
    checkOutput("midrst_head", 64'(head_idx), 64'd0);
    checkOutput("midrst_err", 64'(err), 64'd0);
    acc_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("midrst_no_req", 64'(acc_log.size()), 64'd0);
    checkOutput("midrst_valid_idle", 64'(dcif.dc_req_valid), 64'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/sdq_drain_ctrl.md
Name: sdq_drain_ctrl

Overview:
Read-side controller for the 17-entry x 64-bit store data queue RAM. It tracks committed stores and reads their data from the RAM's asynchronous read port in program order. It presents the data to the D-cache over a valid/ready request channel and frees entries back to the enqueue side only when the cache acks them. A cache nack rewinds the read pointer so that every unacked store is replayed in order.

Parameters:
ENTRIES, 17, number of SDQ entries; the pointer wrap point, not required to be a power of two
DATA_W, 64, store data width
IDX_W, 5, entry index width; must satisfy 2^IDX_W >= ENTRIES
CNT_W, 5, width of the occupancy counters; must hold the value ENTRIES

Ports:
clock  in  1  single clock for all state
reset  in  1  synchronous, active-high reset
commit_valid  in  1  the oldest uncommitted SDQ entry is committed this cycle; in order, at most one per cycle
mem_r_en  out  1  SDQ RAM read enable
mem_r_addr  out  IDX_W  SDQ RAM read address
mem_r_data  in  DATA_W  SDQ RAM read data; combinational from mem_r_addr
dc_req_valid  out  1  store data request to the D-cache is valid
dc_req_ready  in  1  D-cache accepts the request
dc_req_idx  out  IDX_W  SDQ index of the request
dc_req_data  out  DATA_W  store data
dc_ack  in  1  oldest in-flight store completed, in order
dc_nack  in  1  D-cache rejected all in-flight stores; replay from the oldest
deq_free  out  1  pulse: entry deq_idx is released to the enqueue side
deq_idx  out  IDX_W  index released
head_idx  out  IDX_W  oldest unacked entry
err  out  1  sticky protocol error flag

Behaviour:
State:
- head: oldest unacked entry.
- rptr: next entry to read from the RAM.
- n_commit (0..ENTRIES): committed, not yet acked.
- n_issued (0..ENTRIES): read from the RAM, not yet acked; counts the buffered entry and entries in flight.
- Output register: valid, idx, data.

Reset values: all pointers and counters 0; dc_req_valid=0; dc_req_idx=0; dc_req_data=0; deq_free=0; err=0; mem_r_en=0.

Pointer wrap: any pointer at ENTRIES-1 advances to 0 (16 -> 0). Increment-mod-ENTRIES is never computed from the pointer width.

Read issue (combinational, same cycle):
- rd = (n_issued < n_commit) && (!dc_req_valid || dc_req_ready) && !dc_nack.
- mem_r_en = rd; mem_r_addr = rptr.
- On rd, the next edge loads the output register with {rptr, mem_r_data} and sets valid. rptr advances and n_issued increments.
- If dc_req_valid && dc_req_ready && !rd, valid clears at the next edge.
- The output register holds its value while dc_req_valid && !dc_req_ready. Full throughput is one store per cycle.

Latency: commit_valid high in cycle N -> dc_req_valid high in cycle N+2 when idle.

Commit:
- n_commit increments on commit_valid.
- commit_valid while n_commit==ENTRIES sets err; the commit is dropped.

Ack:
- dc_ack decrements n_commit and n_issued and advances head.
- In the next cycle: deq_free=1 and deq_idx = the old head.
- dc_ack while no accepted request is in flight sets err; the ack is ignored.

Nack:
- dc_nack at the edge: rptr <= head, n_issued <= 0, output valid cleared. No read is issued in the nack cycle; replay starts at the following cycle.
- A handshake in the nack cycle is discarded.

Simultaneous events:
- commit + ack in the same cycle: n_commit is unchanged; n_issued decrements.
- commit + nack in the same cycle: both take effect.
- ack + nack in the same cycle: err is set, the nack is applied, the ack is ignored.

Reset mid-operation: all state returns to reset values in the next cycle. Outstanding committed entries are abandoned; the owner resets the SDQ as a whole.

Decomposition:
- Package sdq_pkg: SDQ_ENTRIES=17, SDQ_DATA_W=64, SDQ_IDX_W=5, a typedef sdq_idx_t, and a function sdq_ptr_inc() implementing mod-ENTRIES increment.
- Sub-module sdq_out_reg: the single-entry valid/ready output register with hold and load controls.
- Counters, pointers and error logic stay in the top module.

Test Plan:
- Single store: reset, one commit_valid at cycle 5 with mem[0]=0xDEAD_BEEF_0000_0001 and dc_req_ready=1 -> dc_req_valid at cycle 7 with idx=0 and that data; dc_ack at cycle 9 -> deq_free=1, deq_idx=0 at cycle 10; head_idx=1.
- Wrap-around and full: commit 17 back-to-back with ready=1 and an ack each cycle, then 3 more -> indices 0..16,0,1,2 issued in order. An 18th commit while n_commit=17 -> err=1.
- Backpressure: commit 3 with ready=0 for 4 cycles -> dc_req_idx=0 and data held stable, mem_r_en=0. Release ready -> idx 0,1,2 on consecutive cycles.
- Nack replay: 4 entries issued and accepted, ack idx 0, then dc_nack -> next requests are idx 1,2,3 again with the original data. No deq_free for 1..3 until acked.
- Simultaneous commit + ack with n_commit=2 -> n_commit stays 2; ack + nack in the same cycle -> err=1 and replay from head.
- Reset mid-stream: reset during an active drain with 5 committed -> the next cycle shows dc_req_valid=0, head_idx=0, err=0, and no requests until new commits.
